fa_serial_ctrl: RTL
===================

// Module: fa_serial_ctrl
// PURPOSE
//   Bit-serial adder controller. Accepts a W-bit add request (a + b + cin) and
//   sequences one external registered 1-bit full adder (fa) LSB-first, one bit per cycle.
//   It feeds the carry back and assembles the W-bit sum and carry-out.
//   Sits between a requesting datapath/FSM and a single shared fa cell.
// PARAMETERS
//   W   8   operand/sum width in bits (W >= 1)
// PORTS
//   ck      in   1  clock, rising edge
//   rst     in   1  reset, synchronous, active-high
//   start   in   1  request pulse; sampled only in IDLE
//   a       in   W  operand A; captured on accepted start
//   b       in   W  operand B; captured on accepted start
//   cin     in   1  carry-in; captured on accepted start
//   busy    out  1  1 in RUN and DONE
//   done    out  1  one-cycle pulse: sum/cout valid
//   sum     out  W  result; stable between DONE pulses
//   cout    out  1  carry-out of bit W-1
//   fa_rst  out  1  to fa rst: 1 in IDLE or while rst=1 (combinational)
//   fa_a    out  1  to fa a: operand A bit k in RUN (k<W), else 0
//   fa_b    out  1  to fa b: operand B bit k in RUN (k<W), else 0
//   fa_ci   out  1  to fa ci: k==0 -> captured cin; 0<k<W -> fa_co; else 0
//   fa_s    in   1  from fa s (registered: bit k appears the cycle after it is driven)
//   fa_co   in   1  from fa co (registered, same timing as fa_s)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, shift regs=0.
//   Reset takes priority over every other event, including mid-RUN. In-flight op is discarded.
//   FSM states IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     - start=1 at an edge: opa<=a, opb<=b, cin_r<=cin, cnt<=0, state<=RUN.
//   RUN, cycle cnt=k (0..W):
//     - k<W: drive opa[0]/opb[0]/ci per fa_ci rule; opa, opb shift right at edge.
//     - k>=1: shift fa_s (sum bit k-1) into res shift reg MSB-side at edge.
//     - k==W: also cout<=fa_co, sum<=final res (incl. this fa_s), state<=DONE.
//     - Otherwise cnt<=cnt+1. RUN lasts exactly W+1 cycles. cnt width = clog2(W+1).
//   DONE: done=1 for exactly one cycle; state<=IDLE at next edge.
//   Latency: done is high in the cycle after the (W+1)th edge following the start-sampling edge.
//   Next start is accepted the cycle after DONE, so minimum period is W+3 cycles.
//   start in RUN/DONE is ignored, with no queueing.
//   sum/cout change only on the RUN->DONE edge or on reset. They hold while busy.
//   Carry chain uses only the fa-registered co. The controller never computes the sum itself.
//   fa inputs are 0 outside RUN k<W. fa held in reset in IDLE, so the first co seen is never stale.
//   Arithmetic: {cout,sum} == a + b + cin, modulo 2^(W+1). All values unsigned.
// TESTING (W=8, fa model = registered full adder, reset priority)
//   1. a=0x5A, b=0x33, cin=0 -> done after 9 edges; sum=0x8D, cout=0; busy 1 for 10 cycles.
//   2. a=0xFF, b=0x01, cin=0 -> full carry ripple; sum=0x00, cout=1.
//   3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0, b=0, cin=0 back-to-back -> sum=0x00, cout=0.
//   4. start re-pulsed at RUN k=3 with a=0x01, b=0x01 -> ignored; original result delivered; one done pulse.
//   5. rst=1 at RUN k=4 -> next cycle IDLE, busy=0, sum=0, cout=0, fa_rst=1, no done.
//      Then 0x10+0x20+0 -> 0x30.
//   6. W=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, done 2 edges after start.

Source files
------------

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder controller: sequences one external registered 1-bit full
// adder LSB-first, feeding its registered carry back and assembling the
// W-bit sum and carry-out.
module fa_serial_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         fa_rst,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_ci,
    input  logic         fa_s,
    input  logic         fa_co
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           cin_r;
    logic [W-1:0]   res;
    logic [W-1:0]   res_next;
    logic           feed;

    // Drive the fa cell: operand bits only in RUN while bits remain, carry from
    // captured cin on bit 0 and from the fa's own registered co afterwards.
    always_comb begin
        feed   = (state == RUN) && (cnt < LAST);
        fa_rst = rst || (state == IDLE);
        fa_a   = feed && opa[0];
        fa_b   = feed && opb[0];
        fa_ci  = 1'b0;
        if (feed)
            fa_ci = (cnt == '0) ? cin_r : fa_co;
    end

    // Incoming sum bit enters the result shift register on the MSB side.
    always_comb begin
        res_next        = res >> 1;
        res_next[W-1]   = fa_s;
    end

    // Controller FSM with registered status and result outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            cin_r <= 1'b0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        cin_r <= cin;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    if (cnt != '0)
                        res <= res_next;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= fa_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
